main_mem_responder: RTL and testbench

Multi-cycle backing-memory model that serves the data cache's miss traffic: line refills (read bursts) and write-through word stores. It sits below the cache as the responder end of the cache↔memory request interface. Fixed latency is configurable, and the first word returned is the critical (requested) word. It replaces the single-cycle array so that cache stall paths are exercised under realistic latency.

---
 rtl/main_mem_responder_if.sv | 30 +++
 rtl/main_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_main_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// Cache<->memory request/response bundle.
// master = cache (initiator), slave = backing memory (responder).
interface main_mem_responder_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic [BEAT_W-1:0] rsp_beat;
    logic              rsp_last;
    logic              wr_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, wr_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, wr_done
    );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency backing memory: critical-word-first line refills and
// byte-strobed write-through word stores, all outputs registered.
module main_mem_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned LATENCY     = 3
) (
    input  logic clk,
    input  logic rst,
    main_mem_responder_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam logic [3:0]        LAT       = 4'(LATENCY);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST, ST_WRITE} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [BEAT_W-1:0] n_q, n_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [BEAT_W-1:0] rsp_beat_q, rsp_beat_d;
    logic              rsp_last_q, rsp_last_d;
    logic              wr_done_q, wr_done_d;

    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];
    logic              mem_we;
    logic [XLEN-1:0]   mem_wdata;

    logic              accept;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              addr_unused;

    assign req_idx     = bus.req_addr[IDX_W+1:2];
    assign addr_unused = ^{bus.req_addr[XLEN-1:IDX_W+2], bus.req_addr[1:0]};
    assign accept      = bus.req_valid && req_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            n_q         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_beat_q  <= '0;
            rsp_last_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            n_q         <= n_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_beat_q  <= rsp_beat_d;
            rsp_last_q  <= rsp_last_d;
            wr_done_q   <= wr_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        n_d     = n_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    idx_d   = req_idx;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    cnt_d   = LAT;
                    n_d     = '0;
                    if (LAT != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = bus.req_we ? ST_WRITE : ST_BURST;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = we_q ? ST_WRITE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (n_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    n_d     = '0;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so beat 0 lands on the
    // edge that enters BURST. The wr_done cycle is spent in IDLE with
    // req_ready held low, giving the extra completion cycle without a state.
    always_comb begin
        mem_we    = (state_q == ST_WRITE);
        mem_wdata = mem_q[idx_q];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                mem_wdata[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end

        rd_idx      = {idx_d[IDX_W-1:BEAT_W], idx_d[BEAT_W-1:0] + n_d};
        rsp_valid_d = (state_d == ST_BURST);
        rsp_data_d  = '0;
        rsp_beat_d  = '0;
        rsp_last_d  = 1'b0;
        if (rsp_valid_d) begin
            rsp_data_d = mem_q[rd_idx];
            rsp_beat_d = rd_idx[BEAT_W-1:0];
            rsp_last_d = (n_d == LAST_BEAT);
        end

        wr_done_d   = mem_we;
        req_ready_d = (state_d == ST_IDLE) && !wr_done_d;
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_beat  = rsp_beat_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.wr_done   = wr_done_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench: one responder at LATENCY=3 and one at LATENCY=0 sharing
// stimulus; sel steers the request to one of them and muxes its outputs.
module tb_main_mem_responder;
    localparam int unsigned LAT_M = 3;
    localparam int unsigned DEPTH = 16384;

    typedef logic [31:0] line_t [4];

    logic clk;
    logic rst;
    logic sel;
    logic req_valid;
    logic req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_beat;
    logic        o_last;
    logic        o_done;

    int unsigned total;
    int unsigned bad;
    line_t       exp_line;

    main_mem_responder_if #(.XLEN(32), .LINE_WORDS(4)) m_if ();
    main_mem_responder_if #(.XLEN(32), .LINE_WORDS(4)) z_if ();

    main_mem_responder #(
        .XLEN(32), .DEPTH_WORDS(DEPTH), .LINE_WORDS(4), .LATENCY(LAT_M)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(m_if)
    );

    main_mem_responder #(
        .XLEN(32), .DEPTH_WORDS(DEPTH), .LINE_WORDS(4), .LATENCY(0)
    ) u_dut_lat0 (
        .clk(clk), .rst(rst), .bus(z_if)
    );

    assign m_if.req_valid = req_valid & ~sel;
    assign m_if.req_we    = req_we;
    assign m_if.req_addr  = req_addr;
    assign m_if.req_wdata = req_wdata;
    assign m_if.req_wstrb = req_wstrb;
    assign z_if.req_valid = req_valid & sel;
    assign z_if.req_we    = req_we;
    assign z_if.req_addr  = req_addr;
    assign z_if.req_wdata = req_wdata;
    assign z_if.req_wstrb = req_wstrb;

    assign o_ready = sel ? z_if.req_ready : m_if.req_ready;
    assign o_valid = sel ? z_if.rsp_valid : m_if.rsp_valid;
    assign o_data  = sel ? z_if.rsp_data  : m_if.rsp_data;
    assign o_beat  = sel ? z_if.rsp_beat  : m_if.rsp_beat;
    assign o_last  = sel ? z_if.rsp_last  : m_if.rsp_last;
    assign o_done  = sel ? z_if.wr_done   : m_if.wr_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_data"},  o_data,       32'd0);
        check({tag, "_beat"},  32'(o_beat),  32'd0);
        check({tag, "_last"},  32'(o_last),  32'd0);
        check({tag, "_done"},  32'(o_done),  32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned k;
        k = 0;
        while (!o_ready && k < 50) begin
            tick();
            k++;
        end
        check(tag, 32'(o_ready), 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned k;
        int unsigned lat;
        lat = sel ? 0 : LAT_M;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        req_valid = 1'b1;
        wait_ready("wr_ready");
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!o_done && k < 50) begin
            check("wr_rdy_low", 32'(o_ready), 32'd0);
            tick();
            k++;
        end
        check("wr_lat", k, lat + 1);
        check("wr_done_rdy", 32'(o_ready), 32'd0);
        tick();
        check("wr_done_pulse", 32'(o_done), 32'd0);
        check("wr_rdy_back", 32'(o_ready), 32'd1);
    endtask

    task automatic rd(input logic [31:0] addr, input line_t line);
        int unsigned k;
        int unsigned lat;
        logic [1:0]  w;
        lat = sel ? 0 : LAT_M;
        req_we    = 1'b0;
        req_addr  = addr;
        req_valid = 1'b1;
        wait_ready("rd_ready");
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!o_valid && k < 50) begin
            tick();
            k++;
        end
        check("rd_lat", k, lat);
        for (int unsigned n = 0; n < 4; n++) begin
            w = addr[3:2] + n[1:0];
            check("rd_valid", 32'(o_valid), 32'd1);
            check("rd_data", o_data, line[w]);
            check("rd_beat", 32'(o_beat), 32'(w));
            check("rd_last", 32'(o_last), 32'(n == 3));
            check("rd_rdy_low", 32'(o_ready), 32'd0);
            tick();
        end
        check("rd_end_valid", 32'(o_valid), 32'd0);
        check("rd_end_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        total = 0;
        bad = 0;
        sel = 1'b0;
        rst = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (2) tick();
        check_reset_outs("rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_reset_outs("post_rst");

        // Preload via full-strobe writes.
        wr(32'h100, 32'hA0, 4'hF);
        wr(32'h104, 32'hA1, 4'hF);
        wr(32'h108, 32'hA2, 4'hF);
        wr(32'h10C, 32'hA3, 4'hF);
        wr(32'h040, 32'h40404040, 4'hF);
        wr(32'h044, 32'h44, 4'hF);
        wr(32'h048, 32'h48, 4'hF);
        wr(32'h04C, 32'h4C, 4'hF);
        wr(32'h200, 32'h11223344, 4'hF);
        wr(32'h204, 32'h204, 4'hF);
        wr(32'h208, 32'h208, 4'hF);
        wr(32'h20C, 32'h20C, 4'hF);

        exp_line = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        rd(32'h100, exp_line);
        rd(32'h108, exp_line);
        rd(32'h10F, exp_line);

        wr(32'h200, 32'hAABBCCDD, 4'b0101);
        exp_line = '{32'h11BB33DD, 32'h204, 32'h208, 32'h20C};
        rd(32'h200, exp_line);
        wr(32'h200, 32'hFFFFFFFF, 4'b0000);
        rd(32'h204, exp_line);

        wr(32'h200, 32'hCAFEF00D, 4'hF);
        exp_line = '{32'hCAFEF00D, 32'h204, 32'h208, 32'h20C};
        rd(DEPTH * 4 + 32'h200, exp_line);

        // Pending write aborted by reset must not reach storage.
        req_we = 1'b1;
        req_addr = 32'h40;
        req_wdata = 32'hDEADBEEF;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check_reset_outs("abort_wr");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset during beat 1 of a burst.
        req_we = 1'b0;
        req_addr = 32'h40;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!o_valid && k < 50) begin
            tick();
            k++;
        end
        tick();
        check("mid_beat1", 32'(o_beat), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_outs("mid_burst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_ready", 32'(o_ready), 32'd1);
        exp_line = '{32'h40404040, 32'h44, 32'h48, 32'h4C};
        rd(32'h40, exp_line);

        // LATENCY=0 responder: back-to-back read then write.
        sel = 1'b1;
        tick();
        wr(32'h300, 32'hB0, 4'hF);
        wr(32'h304, 32'hB1, 4'hF);
        wr(32'h308, 32'hB2, 4'hF);
        wr(32'h30C, 32'hB3, 4'hF);
        req_we = 1'b0;
        req_addr = 32'h300;
        req_valid = 1'b1;
        tick();
        req_we = 1'b1;
        req_addr = 32'h304;
        req_wdata = 32'h77;
        req_wstrb = 4'hF;
        for (int unsigned n = 0; n < 4; n++) begin
            check("b2b_valid", 32'(o_valid), 32'd1);
            check("b2b_data", o_data, 32'hB0 + n);
            check("b2b_beat", 32'(o_beat), n);
            check("b2b_last", 32'(o_last), 32'(n == 3));
            check("b2b_rdy_low", 32'(o_ready), 32'd0);
            tick();
        end
        check("b2b_ready", 32'(o_ready), 32'd1);
        check("b2b_idle_valid", 32'(o_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        check("b2b_wr_acc", 32'(o_ready), 32'd0);
        check("b2b_done_early", 32'(o_done), 32'd0);
        tick();
        check("b2b_done", 32'(o_done), 32'd1);
        check("b2b_done_rdy", 32'(o_ready), 32'd0);
        tick();
        check("b2b_rdy_back", 32'(o_ready), 32'd1);
        exp_line = '{32'hB0, 32'h77, 32'hB2, 32'hB3};
        rd(32'h304, exp_line);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
